// File: rtl/butterfly_pipe.sv
// butterfly_pipe: four-stage Kyber butterfly (NTT CT / INTT GS / MUL / BYPASS).
// The valid/ready pipeline stalls all four stages together when the output is
// held. Result registers are the final stage, so latency is 4 cycles.
module butterfly_pipe #(
  parameter int WIDTH     = 16,
  parameter int Q         = 3329,
  parameter int TAG_W     = 8,
  parameter int INTT_HALF = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int STAGES = 4;
  localparam logic [1:0] M_NTT = 2'b00, M_INTT = 2'b01, M_MUL = 2'b10;
  localparam logic [WIDTH:0]   QW = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH:0] QK = (2*WIDTH+1)'(Q);
  // Barrett constant floor(2^(2W)/Q); with p < 2^(2W) the quotient estimate
  // is short by at most one, so a single conditional subtract suffices.
  localparam logic [2*WIDTH:0] MU = {1'b1, {(2*WIDTH){1'b0}}} / QK;

  typedef struct packed {
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a, b, w, s, m;
  } s1_t;

  typedef struct packed {
    logic [1:0]         mode;
    logic [TAG_W-1:0]   tag;
    logic [WIDTH-1:0]   a, b, s;
    logic [2*WIDTH-1:0] p;
  } s2_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a, b, s, r;
  } s3_t;

  // Canonical-input modular helpers: one correction step each.
  function automatic logic [WIDTH-1:0] addq(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= QW) t = t - QW;
    return WIDTH'(t);
  endfunction

  function automatic logic [WIDTH-1:0] subq(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (x < y) t = t + QW;
    return WIDTH'(t);
  endfunction

  // x/2 mod Q: odd values borrow one Q to become even first.
  function automatic logic [WIDTH-1:0] halfq(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + QW) : {1'b0, x};
    return WIDTH'(t >> 1);
  endfunction

  logic [STAGES:1]    vld_pipe;
  logic               stall;
  s1_t                s1_q;
  s2_t                s2_q;
  s3_t                s3_q;
  logic [WIDTH-1:0]   mc;
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH:0]   qe, qq;
  logic [WIDTH:0]     rw;
  logic [WIDTH-1:0]   r_d, c_d, d_d;

  assign stall     = vld_pipe[STAGES] && !out_ready;
  assign in_ready  = rst_n && !stall;
  assign out_valid = vld_pipe[STAGES];
  assign busy      = |vld_pipe;

  // Valid shift register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n)      vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  // S2 multiplicand select; BYPASS multiplies nothing.
  always_comb begin
    mc = '0;
    case (s1_q.mode)
      M_NTT:   mc = s1_q.b;
      M_INTT:  mc = s1_q.m;
      M_MUL:   mc = s1_q.a;
      default: mc = '0;
    endcase
  end

  assign p_d = {{WIDTH{1'b0}}, mc} * {{WIDTH{1'b0}}, s1_q.w};

  // S3 Barrett reduction of the registered product.
  always_comb begin
    qe  = (2*WIDTH+1)'(({{(2*WIDTH+1){1'b0}}, s2_q.p} * {{(2*WIDTH){1'b0}}, MU}) >> (2*WIDTH));
    qq  = qe * QK;
    rw  = (WIDTH+1)'({1'b0, s2_q.p} - qq);
    r_d = (rw >= QW) ? WIDTH'(rw - QW) : WIDTH'(rw);
  end

  // S4 post add/sub per mode, optional INTT halving.
  always_comb begin
    c_d = s3_q.a;
    d_d = s3_q.b;
    case (s3_q.mode)
      M_NTT: begin
        c_d = addq(s3_q.a, s3_q.r);
        d_d = subq(s3_q.a, s3_q.r);
      end
      M_INTT: begin
        c_d = (INTT_HALF != 0) ? halfq(s3_q.s) : s3_q.s;
        d_d = (INTT_HALF != 0) ? halfq(s3_q.r) : s3_q.r;
      end
      M_MUL: begin
        c_d = s3_q.r;
        d_d = s3_q.b;
      end
      default: begin
        c_d = s3_q.a;
        d_d = s3_q.b;
      end
    endcase
  end

  // Datapath stage registers; they only move when the pipe advances.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_q <= '{mode: mode, tag: in_tag, a: a, b: b, w: w,
                s: addq(a, b), m: subq(a, b)};
      s2_q <= '{mode: s1_q.mode, tag: s1_q.tag, a: s1_q.a, b: s1_q.b,
                s: s1_q.s, p: p_d};
      s3_q <= '{mode: s2_q.mode, tag: s2_q.tag, a: s2_q.a, b: s2_q.b,
                s: s2_q.s, r: r_d};
    end
  end

  // Output registers; cleared on reset, held during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c       <= '0;
      d       <= '0;
      out_tag <= '0;
    end else if (!stall) begin
      c       <= c_d;
      d       <= d_d;
      out_tag <= s3_q.tag;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed + random stimulus against a queue-based model.
// Two instances (INTT_HALF=0/1) see identical stimulus and timing.
module tb_butterfly_pipe;
  localparam int WIDTH = 16, Q = 3329, TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, out_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a, b, w;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready0, out_valid0, busy0;
  logic             in_ready1, out_valid1, busy1;
  logic [WIDTH-1:0] c0, d0, c1, d1;
  logic [TAG_W-1:0] tag0, tag1;

  butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W), .INTT_HALF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .mode(mode), .a(a), .b(b), .w(w), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .d(d0),
    .out_tag(tag0), .busy(busy0));

  butterfly_pipe #(.WIDTH(WIDTH), .Q(Q), .TAG_W(TAG_W), .INTT_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .mode(mode), .a(a), .b(b), .w(w), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .c(c1), .d(d1),
    .out_tag(tag1), .busy(busy1));

  always #5 clk = ~clk;

  // prog = number of non-stalled edges since the op entered the pipe.
  typedef struct { int tag; int c; int d; int ch; int dh; int prog; } exp_t;
  exp_t q[$];
  int   cur_c, cur_d, cur_ch, cur_dh;
  int   n_chk = 0, n_fail = 0;
  bit   stall_prev = 0, after_rst = 0, rdone = 0;
  bit   exp_ov, exp_rdy;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference arithmetic straight from the mode definitions.
  function automatic void ref_op(input int md, input int x, input int y, input int tw,
                                 input int half, output int rc, output int rd);
    longint t;
    case (md)
      0: begin
        t  = (longint'(y) * tw) % Q;
        rc = int'((x + t) % Q);
        rd = int'((x - t + Q) % Q);
      end
      1: begin
        rc = (x + y) % Q;
        rd = int'((longint'((x - y + Q) % Q) * tw) % Q);
        if (half != 0) begin
          rc = (rc * ((Q + 1) / 2)) % Q;
          rd = (rd * ((Q + 1) / 2)) % Q;
        end
      end
      2: begin
        rc = int'((longint'(x) * tw) % Q);
        rd = y;
      end
      default: begin
        rc = x;
        rd = y;
      end
    endcase
  endfunction

  // Scoreboard: advance model, compare handshake and data, record accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready0", in_ready0, 0);
      chk("rst_in_ready1", in_ready1, 0);
      q.delete();
      stall_prev = 0;
      after_rst  = 1;
    end else begin
      if (after_rst) begin
        chk("rst_c0", c0, 0);     chk("rst_d0", d0, 0);   chk("rst_tag0", tag0, 0);
        chk("rst_c1", c1, 0);     chk("rst_d1", d1, 0);   chk("rst_tag1", tag1, 0);
        after_rst = 0;
      end
      if (!stall_prev) foreach (q[i]) q[i].prog++;
      exp_ov  = (q.size() > 0) && (q[0].prog == 4);
      exp_rdy = !(exp_ov && !out_ready);
      chk("busy0", busy0, q.size() > 0);
      chk("busy1", busy1, q.size() > 0);
      chk("out_valid0", out_valid0, exp_ov);
      chk("out_valid1", out_valid1, exp_ov);
      chk("in_ready0", in_ready0, exp_rdy);
      chk("in_ready1", in_ready1, exp_rdy);
      if (exp_ov) begin
        chk("tag0", tag0, q[0].tag);
        chk("c0", c0, q[0].c);
        chk("d0", d0, q[0].d);
        chk("tag1", tag1, q[0].tag);
        chk("c1_half", c1, q[0].ch);
        chk("d1_half", d1, q[0].dh);
        if (out_ready) void'(q.pop_front());
      end
      stall_prev = exp_ov && !out_ready;
      if (in_valid && exp_rdy)
        q.push_back('{tag: int'(in_tag), c: cur_c, d: cur_d, ch: cur_ch, dh: cur_dh, prog: 0});
    end
  end

  // Present one op and hold it until accepted; ec<0 means use the model.
  task automatic send(input int md, input int x, input int y, input int tw, input int tg,
                      input int ec = -1, input int ed = -1, input int ech = -1, input int edh = -1);
    bit acc, done;
    mode = 2'(md); a = WIDTH'(x); b = WIDTH'(y); w = WIDTH'(tw); in_tag = TAG_W'(tg);
    in_valid = 1'b1;
    if (ec < 0) begin
      ref_op(md, x, y, tw, 0, cur_c, cur_d);
      ref_op(md, x, y, tw, 1, cur_ch, cur_dh);
    end else begin
      cur_c = ec; cur_d = ed; cur_ch = ech; cur_dh = edh;
    end
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      done = acc;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rq();
    return int'($urandom_range(0, Q - 1));
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; mode = '0;
    a = '0; b = '0; w = '0; in_tag = '0;
    cur_c = 0; cur_d = 0; cur_ch = 0; cur_dh = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Directed values
    send(0, 1000, 2, 17, 8'h11, 1034, 966, 1034, 966);    idle(6);
    send(0, 3000, 3328, 2, 8'h22, 2998, 3002, 2998, 3002); idle(6);
    send(1, 3237, 602, 3121, 8'h33, 510, 1205, 255, 2267); idle(6);
    send(2, 3328, 77, 3328, 8'h44, 1, 77, 1, 77);
    send(3, 5, 9, 0, 8'h55, 5, 9, 5, 9);
    idle(6);

    // Back-to-back stream with a three-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++) send(i % 4, rq(), rq(), rq(), i);
        idle(1);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    idle(10);

    // Reset with three ops in flight, then a fresh op
    send(0, rq(), rq(), rq(), 8'hA0);
    send(1, rq(), rq(), rq(), 8'hA1);
    send(2, rq(), rq(), rq(), 8'hA2);
    in_valid = 0;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    send(0, 1000, 2, 17, 8'hB0, 1034, 966, 1034, 966);
    idle(8);

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(int'($urandom_range(0, 3)), rq(), rq(), rq(), int'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 0;
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join

    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Pipelined, parametrised successor of the single-cycle Kyber butterfly.
- Supports four modes: NTT Cooley-Tukey butterfly, INTT Gentleman-Sande butterfly with optional divide-by-2, pointwise twiddle multiply, and bypass.
- Sits between the coefficient-RAM read port and the write-back path of the NTT engine.
- Uses valid/ready handshakes on both sides, a pass-through tag for the write-back address, and full backpressure support.

Parameters:
- WIDTH, 16, coefficient/twiddle width in bits.
- Q, 3329, modulus. Must satisfy Q < 2^(WIDTH-1).
- TAG_W, 8, width of the sideband tag carried with each operation.
- INTT_HALF, 0. When 1, both INTT outputs are multiplied by 2^-1 mod Q.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block accepts an operation this cycle.
- mode  in  2  00 NTT, 01 INTT, 10 MUL, 11 BYPASS.
- a  in  WIDTH  operand a, canonical in [0,Q-1].
- b  in  WIDTH  operand b, canonical in [0,Q-1].
- w  in  WIDTH  twiddle, canonical in [0,Q-1].
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- c  out  WIDTH  result c, canonical.
- d  out  WIDTH  result d, canonical.
- out_tag  out  TAG_W  tag of the current result.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All stage valid bits clear.
  - out_valid=0, c=0, d=0, out_tag=0, busy=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-operation discards all in-flight operations; none appear at the output afterwards.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = rst_n && !stall.
  - A stall freezes all four stages together; c, d and out_tag hold stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed.
- Latency: exactly 4 cycles from input transfer to out_valid with no stall; throughput 1 op/cycle.
- Order: results emerge strictly in input order. mode and tag travel with their data.
- Pipeline stages:
  - S1: register operands; compute pre-add s=(a+b) mod Q and pre-sub m=(a-b) mod Q.
  - S2: register the 2*WIDTH-bit product p. Multiplicand is b (NTT), m (INTT), a (MUL), or none (BYPASS).
  - S3: exact reduction r = p mod Q to the canonical range. Barrett or equivalent, contained in this one stage.
  - S4: post-add/sub and optional halving; drives the output registers.
- Mode 00 NTT: t=b*w mod Q; c=(a+t) mod Q; d=(a-t) mod Q.
- Mode 01 INTT: c=(a+b) mod Q; d=((a-b)*w) mod Q.
  - If INTT_HALF=1, both outputs are halved mod Q: x even -> x>>1; x odd -> (x+Q)>>1.
- Mode 10 MUL: c=a*w mod Q; d=b unchanged.
- Mode 11 BYPASS: c=a; d=b.
- All mod-Q add/sub use a single conditional correction, which is valid for canonical inputs. Intermediate sums are WIDTH+1 bits.
- Non-canonical operands (>=Q): outputs are undefined. out_valid and ordering are still correct.
- busy is high whenever any S1-S4 valid bit is set, including during a stall.

Test Plan:
1. NTT, a=1000, b=2, w=17, out_ready=1 -> 4 cycles later out_valid=1, c=1034, d=966, out_tag echoed.
2. NTT wrap, a=3000, b=3328, w=2 -> c=2998, d=3002 (both add and sub wrap).
3. INTT, a=3237 (0x0CA5), b=602 (0x025A), w=3121:
   - INTT_HALF=0 -> c=510, d=1205.
   - INTT_HALF=1 -> c=255, d=2267.
4. MUL a=3328, b=77, w=3328 -> c=1, d=77. BYPASS a=5, b=9 -> c=5, d=9.
5. Back-to-back stream of 8 ops with tags 0..7 and mixed modes; out_ready=0 for cycles 5-7 -> in_ready=0 during the stall, outputs held stable, all 8 results in tag order with none lost or duplicated.
6. Three ops in flight, rst_n=0 for one cycle -> next cycle out_valid=0, busy=0, c=d=0. No stale results ever emerge. A new op issued after reset returns with latency 4.
